// File: rtl/dmac_pkg.sv
// Shared definitions for the DMAC multiply-accumulate sequencer.
package dmac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DMAC_OPW = 16;
    localparam int ACC_W    = 32;

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups with a rippled
// group carry between them.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [8:0]  gc;

    // Bit generate/propagate, in-group lookahead carries, group carry chain.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        gc    = '0;
        gc[0] = ci;
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
            gc[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        s  = p ^ c;
        co = gc[8];
    end

endmodule

// File: rtl/dmac_seq.sv
// Multi-cycle unsigned multiply-accumulate sequencer (acc += a*b).
// One shared cla32 forms the shift-add partial products and then the
// final accumulate. OPW must satisfy 2*OPW <= 32 so products never carry out.
module dmac_seq
    import dmac_pkg::*;
#(
    parameter int OPW = DMAC_OPW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clr,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    localparam int CNT_W = (OPW > 1) ? $clog2(OPW) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [OPW-1:0]     a_r;
    logic [OPW-1:0]     b_r;
    logic [ACC_W-1:0]   prod;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   add_x;
    logic [ACC_W-1:0]   add_y;
    logic [ACC_W-1:0]   add_s;
    logic               add_co;
    logic               last_bit;

    assign last_bit = (cnt == CNT_W'(OPW - 1));

    cla32 u_add (
        .a  (add_x),
        .b  (add_y),
        .ci (1'b0),
        .s  (add_s),
        .co (add_co)
    );

    // Adder operand mux: partial products in MUL, accumulate in ACC.
    always_comb begin
        add_x = '0;
        add_y = '0;
        case (state)
            MUL: begin
                add_x = prod;
                if (b_r[cnt]) begin
                    add_y = ACC_W'(a_r) << cnt;
                end
            end
            ACC: begin
                add_x = acc;
                add_y = prod;
            end
            default: begin
                add_x = '0;
                add_y = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, shift-add product build, accumulate and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r  <= '0;
            b_r  <= '0;
            prod <= '0;
            cnt  <= '0;
            acc  <= '0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // clr together with start clears first, so the result is a*b.
                    if (clr) begin
                        acc <= '0;
                        ovf <= 1'b0;
                    end
                    if (start) begin
                        a_r  <= a;
                        b_r  <= b;
                        prod <= '0;
                        cnt  <= '0;
                    end
                end
                MUL: begin
                    if (b_r[cnt]) begin
                        prod <= add_s;
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                ACC: begin
                    acc <= add_s;
                    ovf <= ovf | add_co;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
